// File: rtl/cordic_result_collector.sv
// Buffers CORDIC cos/sin result pairs in a FIFO and streams them out as cos, sin words with frame marking.
// Optional build macro: CORDIC_RESULT_OVF_CNT_EN enables the saturating dropped-result counter on oOvf_count.
module cordic_result_collector #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned N_RESULTS = 17
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iData_valid,
    input  logic [31:0]               iData_cos,
    input  logic [31:0]               iData_sin,
    output logic                      oOut_valid,
    input  logic                      iOut_ready,
    output logic [31:0]               oOut_data,
    output logic                      oOut_last,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oFull,
    output logic                      oEmpty,
    output logic                      oDone,
    output logic                      oOverflow,
    output logic [7:0]                oOvf_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 32;
    localparam int unsigned FW = 8;

    typedef enum logic [1:0] {IDLE, COS, SIN} state_t;

    state_t            state, state_nxt;
    logic [2*DW-1:0]   mem [DEPTH];
    logic [2*DW-1:0]   head;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic [FW-1:0]     frame_cnt;
    logic              full, empty, pop, wr_en, last, done, overflow;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    // The sin transfer frees the head slot, so a full FIFO can still accept in that cycle.
    assign pop       = (state == SIN) && iOut_ready;
    assign wr_en     = iData_valid && (!full || pop);
    assign count_nxt = count + CW'(wr_en) - CW'(pop);

    // Output FSM: next state and word presentation.
    always_comb begin
        state_nxt  = state;
        oOut_valid = 1'b0;
        oOut_data  = '0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty || wr_en) state_nxt = COS;
            end
            COS: begin
                oOut_valid = 1'b1;
                oOut_data  = head[2*DW-1:DW];
                if (iOut_ready) state_nxt = SIN;
            end
            SIN: begin
                oOut_valid = 1'b1;
                oOut_data  = head[DW-1:0];
                last       = (frame_cnt == FW'(N_RESULTS - 1));
                if (iOut_ready) state_nxt = (count_nxt != '0) ? COS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oOut_last = last;

    // Control state: FSM, pointers, occupancy, frame tracking and sticky flags.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                frame_cnt <= last ? '0 : frame_cnt + FW'(1);
                if (last) done <= 1'b1;
            end
            if (iData_valid && !wr_en) overflow <= 1'b1;
        end
    end

    // Pair storage; contents are don't-care after reset.
    always_ff @(posedge iClk) begin
        if (wr_en) mem[wr_ptr] <= {iData_cos, iData_sin};
    end

`ifdef CORDIC_RESULT_OVF_CNT_EN
    logic [7:0] ovf_cnt;

    // Saturating count of dropped results.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            ovf_cnt <= '0;
        end else if (iData_valid && !wr_en && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    assign oOvf_count = ovf_cnt;
`else
    assign oOvf_count = '0;
`endif

    assign oCount    = count;
    assign oFull     = full;
    assign oEmpty    = empty;
    assign oDone     = done;
    assign oOverflow = overflow;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed bench for cordic_result_collector with a word-level scoreboard and a pair-occupancy model.
module tb_cordic_result_collector;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NRES  = 17;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_cos, in_sin;
    logic          out_valid, out_ready, out_last;
    logic [31:0]   out_data;
    logic [CW-1:0] count;
    logic          full, empty, done, overflow;
    logic [7:0]    ovf_count;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    int   m_count, m_in_idx, m_ovf_cnt;
    logic m_want_sin, m_done, m_ovf;

    cordic_result_collector #(.DEPTH(DEPTH), .N_RESULTS(NRES)) dut (
        .iClk(clk), .iReset_n(rst_n), .iData_valid(in_valid), .iData_cos(in_cos),
        .iData_sin(in_sin), .oOut_valid(out_valid), .iOut_ready(out_ready),
        .oOut_data(out_data), .oOut_last(out_last), .oCount(count), .oFull(full),
        .oEmpty(empty), .oDone(done), .oOverflow(overflow), .oOvf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count    = 0;
        m_in_idx   = 0;
        m_ovf_cnt  = 0;
        m_want_sin = 1'b0;
        m_done     = 1'b0;
        m_ovf      = 1'b0;
    endtask

    // Check DUT against the model, then advance the model across the coming rising edge.
    task automatic tick();
        logic xfer, sin_pop, accept;
        #1;
        check("count", 32'(count), 32'(m_count));
        check("full", 32'(full), 32'(m_count == int'(DEPTH)));
        check("empty", 32'(empty), 32'(m_count == 0));
        check("valid", 32'(out_valid), 32'(m_count != 0));
        check("done", 32'(done), 32'(m_done));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("ovf_count", 32'(ovf_count), 32'(m_ovf_cnt));
        if (!out_valid) begin
            check("idle_data", out_data, 32'h0);
            check("idle_last", 32'(out_last), 32'h0);
        end else if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(out_valid), 32'h0);
        end else begin
            check("data", out_data, exp_q[0].data);
            check("last", 32'(out_last), 32'(exp_q[0].last));
        end
        if (!rst_n) begin
            model_clear();
        end else begin
            xfer    = out_valid && out_ready && (exp_q.size() != 0);
            sin_pop = xfer && m_want_sin;
            accept  = in_valid && ((m_count < int'(DEPTH)) || sin_pop);
            if (xfer) begin
                if (sin_pop && exp_q[0].last) m_done = 1'b1;
                void'(exp_q.pop_front());
                m_want_sin = !m_want_sin;
                if (sin_pop) m_count--;
            end
            if (accept) begin
                exp_q.push_back('{data: in_cos, last: 1'b0});
                exp_q.push_back('{data: in_sin, last: (m_in_idx == int'(NRES) - 1)});
                m_in_idx = (m_in_idx == int'(NRES) - 1) ? 0 : m_in_idx + 1;
                m_count++;
            end else if (in_valid) begin
                m_ovf = 1'b1;
`ifdef CORDIC_RESULT_OVF_CNT_EN
                if (m_ovf_cnt < 255) m_ovf_cnt++;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] c, input logic [31:0] s);
        in_valid = 1'b1;
        in_cos   = c;
        in_sin   = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((m_count != 0 || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'(out_valid), 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cos    = '0;
        in_sin    = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_last", 32'(out_last), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // Single result with consumer always ready.
        out_ready = 1'b1;
        push(32'h0000_8000, 32'h0000_0000);
        check("single_t1_valid", 32'(out_valid), 32'h1);
        check("single_t1_data", out_data, 32'h0000_8000);
        tick();
        check("single_t2_data", out_data, 32'h0);
        check("single_t2_valid", 32'(out_valid), 32'h1);
        tick();
        check("single_t3_valid", 32'(out_valid), 32'h0);
        tick();

        // Backpressure while presenting cos.
        out_ready = 1'b0;
        push(32'hCAFE_0001, 32'hBEEF_0002);
        repeat (5) tick();
        check("bp_hold", out_data, 32'hCAFE_0001);
        out_ready = 1'b1;
        tick();
        check("bp_sin", out_data, 32'hBEEF_0002);
        tick();
        check("bp_idle", 32'(out_valid), 32'h0);

        // One full frame at 4-cycle spacing.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < int'(NRES); i++) begin
            push($urandom, $urandom);
            repeat (3) tick();
        end
        repeat (4) tick();
        check("frame_done", 32'(done), 32'h1);

        // Reset during SIN with three pairs stored.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h1000 + 32'(i), 32'h2000 + 32'(i));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid_in_sin", out_data, 32'h2000);
        do_reset();
        check("mid_valid", 32'(out_valid), 32'h0);
        check("mid_count", 32'(count), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        tick();

        // Full FIFO with a write landing on the sin pop.
        out_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) push(32'hA000 + 32'(i), 32'hB000 + 32'(i));
        check("fp_full", 32'(full), 32'h1);
        out_ready = 1'b1;
        tick();
        push(32'hC0C0_C0C0, 32'h5151_5151);
        out_ready = 1'b0;
        check("fp_count", 32'(count), 32'd8);
        check("fp_ovf", 32'(overflow), 32'h0);
        drain();

        // Overflow: ten results into an eight-deep FIFO with no consumer.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_cos = 32'h3000 + 32'(i);
            in_sin = 32'h4000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_count8", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'h1);
`ifdef CORDIC_RESULT_OVF_CNT_EN
        check("ovf_cnt", 32'(ovf_count), 32'd2);
`else
        check("ovf_cnt", 32'(ovf_count), 32'd0);
`endif
        drain();
        check("ovf_sticky", 32'(overflow), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cordic_result_collector.md
CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO depth in cos/sin result pairs (power of 2, 2..64).
REQ-002 The block SHALL have parameter N_RESULTS, default 17, meaning results per frame (1..255).
REQ-003 The block SHALL have port iClk, input, 1 bit: clock, all logic on its rising edge.
REQ-004 The block SHALL have port iReset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port iData_valid, input, 1 bit: CORDIC result strobe, one pulse per result.
REQ-006 The block SHALL have port iData_cos, input, 32 bits: cosine result, sampled when iData_valid=1.
REQ-007 The block SHALL have port iData_sin, input, 32 bits: sine result, sampled when iData_valid=1.
REQ-008 The block SHALL have port oOut_valid, output, 1 bit: output word valid.
REQ-009 The block SHALL have port iOut_ready, input, 1 bit: consumer ready; a transfer occurs when oOut_valid & iOut_ready.
REQ-010 The block SHALL have port oOut_data, output, 32 bits: output word, cos first, then sin of the same pair.
REQ-011 The block SHALL have port oOut_last, output, 1 bit: marks the sin word of the N_RESULTS-th pair of a frame.
REQ-012 The block SHALL have port oCount, output, log2(DEPTH)+1 bits: pairs currently stored.
REQ-013 The block SHALL have ports oFull and oEmpty, output, 1 bit each: oCount==DEPTH and oCount==0.
REQ-014 The block SHALL have port oDone, output, 1 bit: sticky, first frame completely delivered.
REQ-015 The block SHALL have port oOverflow, output, 1 bit: sticky, a result was dropped.
REQ-016 The block SHALL have port oOvf_count, output, 8 bits: count of dropped results.

Function
REQ-017 The block SHALL write {cos,sin} into the FIFO tail when iData_valid=1 and the FIFO is not full, or is full and the head pair pops in that same cycle.
REQ-018 The block SHALL drop a result arriving when full with no pop in that cycle, and set oOverflow.
REQ-019 The block SHALL run the output FSM with states IDLE, COS and SIN; in IDLE oOut_valid=0.
REQ-020 The FSM SHALL go IDLE->COS when oCount>0 or a write completes, so a write at edge t gives oOut_valid=1 in cycle t+1.
REQ-021 In COS the block SHALL set oOut_valid=1 and oOut_data=head cos, and move to SIN on transfer; otherwise it holds, with data stable.
REQ-022 In SIN the block SHALL set oOut_valid=1 and oOut_data=head sin, and pop the head on transfer; it then goes to COS if pairs remain after the pop, else IDLE.
REQ-023 The block SHALL drive oOut_data=0 in IDLE.
REQ-024 The block SHALL count popped pairs modulo N_RESULTS, and set oOut_last=1 in SIN when the counter equals N_RESULTS-1.
REQ-025 The block SHALL set oDone on the first oOut_last transfer and hold it until reset; later frames repeat oOut_last.
REQ-026 When a write and a pop occur in the same cycle, oCount SHALL be unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 Data SHALL leave in arrival order, with no reordering or duplication.

Reset
REQ-029 While iReset_n=0 at a rising edge, the block SHALL clear FSM->IDLE, pointers, oCount, the frame counter, oDone, oOverflow and oOvf_count.
REQ-030 Reset mid-transfer SHALL discard all stored pairs, give oOut_valid=0 in the next cycle, and leave FIFO RAM contents don't-care.
REQ-031 After reset the block SHALL present oEmpty=1, oFull=0, oOut_last=0 and oOut_data=0.

Configuration
REQ-032 With macro CORDIC_RESULT_OVF_CNT_EN defined, oOvf_count SHALL increment per dropped result and saturate at 255.
REQ-033 Without CORDIC_RESULT_OVF_CNT_EN, oOvf_count SHALL be constant 0 with no counter logic; oOverflow behaves identically in both builds.

Verification
REQ-034 Single result: reset, cos=32'h0000_8000, sin=32'h0000_0000 with iOut_ready=1 -> cycle t+1 gives 32'h0000_8000, t+2 gives 32'h0, t+3 oOut_valid=0.
REQ-035 Backpressure: iOut_ready=0 for 5 cycles in COS -> oOut_data held at the cos value; the sin word transfers 1 cycle after ready rises.
REQ-036 Overflow: DEPTH=8, 10 results with iOut_ready=0 -> oFull=1, oCount=8, oOverflow=1, oOvf_count=2 (0 without macro); the 8 stored pairs drain in order.
REQ-037 Frame: 17 results at a 4-cycle spacing, iOut_ready=1 -> 34 words, oOut_last only on the 34th word, oDone=1 afterwards.
REQ-038 Full plus simultaneous pop: full FIFO, sin transfer and iData_valid in the same cycle -> result accepted, oCount stays 8, oOverflow=0.
REQ-039 Mid-stream reset: reset asserted during SIN with 3 pairs stored -> next cycle oOut_valid=0, oCount=0, oDone=0.
